// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single memory port between an instruction-fetch client and a
//   data client. One memory transaction is in flight at a time; each walks
//   IDLE -> REQ -> RESP -> DELIVER -> IDLE, so a transaction takes at least
//   four cycles. Data requests normally win arbitration. A starvation counter
//   forces a fetch grant after STARVE_LIMIT consecutive data grants that were
//   made while a fetch was waiting.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   if_req_*            fetch request (valid/ready, addr)
//   if_flush            discards the outstanding fetch response
//   if_rsp_*            fetch response (valid/ready, data)
//   d_req_*             data request (valid/ready, addr, we, wdata, wstrb)
//   d_rsp_*             data response for reads and writes (valid/ready, rdata)
//   mem_req_*, mem_*    registered memory request (valid/ready + fields)
//   mem_rsp_*           memory response (valid, rdata), no backpressure
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            if_rsp_ready,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_we,
  input  logic [DW-1:0]   d_req_wdata,
  input  logic [DW/8-1:0] d_req_wstrb,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_rdata,
  input  logic            d_rsp_ready,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_rdata
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_t;

  state_t          state_reg, state_next;
  logic            owner_fetch_reg;   // 1: fetch owns the transaction, 0: data
  logic            drop_reg, drop_next;
  logic [CW-1:0]   starve_cnt_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic            mem_we_reg;
  logic [DW-1:0]   mem_wdata_reg;
  logic [SW-1:0]   mem_wstrb_reg;
  logic [DW-1:0]   rsp_data_reg;

  logic            fetch_wins;
  logic            grant_fetch;
  logic            grant_data;
  logic            flush_fetch;
  logic            capture_rsp;

  // Fetch wins when it is the only requester, or when it has been passed
  // over STARVE_LIMIT times in a row.
  assign fetch_wins  = if_req_valid &&
                       (!d_req_valid || (starve_cnt_reg == CW'(STARVE_LIMIT)));
  assign grant_fetch = (state_reg == IDLE) && fetch_wins;
  assign grant_data  = (state_reg == IDLE) && d_req_valid && !fetch_wins;
  assign flush_fetch = if_flush && owner_fetch_reg;

  // A flush arriving in the same cycle as the memory response drops it too.
  assign capture_rsp = (state_reg == RESP) && mem_rsp_valid &&
                       !(drop_reg || flush_fetch);

  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    case (state_reg)
      IDLE: begin
        if (grant_fetch || grant_data) state_next = REQ;
      end
      REQ: begin
        if (flush_fetch)   drop_next  = 1'b1;
        if (mem_req_ready) state_next = RESP;
      end
      RESP: begin
        if (flush_fetch) drop_next = 1'b1;
        if (mem_rsp_valid) begin
          if (drop_reg || flush_fetch) begin
            state_next = IDLE;
            drop_next  = 1'b0;
          end else begin
            state_next = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (owner_fetch_reg) begin
          if (if_rsp_ready || if_flush) state_next = IDLE;
        end else if (d_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      owner_fetch_reg <= 1'b0;
      drop_reg        <= 1'b0;
      starve_cnt_reg  <= '0;
      mem_addr_reg    <= '0;
      mem_we_reg      <= 1'b0;
      mem_wdata_reg   <= '0;
      mem_wstrb_reg   <= '0;
      rsp_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;

      if (grant_fetch) begin
        owner_fetch_reg <= 1'b1;
        mem_addr_reg    <= if_req_addr;
        mem_we_reg      <= 1'b0;
        mem_wdata_reg   <= '0;
        mem_wstrb_reg   <= '0;
        starve_cnt_reg  <= '0;
      end else if (grant_data) begin
        owner_fetch_reg <= 1'b0;
        mem_addr_reg    <= d_req_addr;
        mem_we_reg      <= d_req_we;
        mem_wdata_reg   <= d_req_wdata;
        mem_wstrb_reg   <= d_req_wstrb;
        // Only a data grant that overtakes a waiting fetch counts.
        if (if_req_valid && (starve_cnt_reg < CW'(STARVE_LIMIT)))
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end

      if (capture_rsp) rsp_data_reg <= mem_rsp_rdata;
    end
  end

  assign if_req_ready  = grant_fetch;
  assign d_req_ready   = grant_data;
  assign mem_req_valid = (state_reg == REQ);
  assign mem_addr      = mem_addr_reg;
  assign mem_we        = mem_we_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_wstrb     = mem_wstrb_reg;
  assign if_rsp_valid  = (state_reg == DELIVER) && owner_fetch_reg;
  assign d_rsp_valid   = (state_reg == DELIVER) && !owner_fetch_reg;
  assign if_rsp_data   = rsp_data_reg;
  assign d_rsp_rdata   = rsp_data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, expected grants, memory
// requests and responses pushed into queues and checked by monitors.
module tb_mem_arbiter;

  logic        clk = 0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_flush;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_rsp_valid, d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_flush(if_flush),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_rsp_ready(if_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .d_rsp_ready(d_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        is_fetch;
  } mem_exp_t;

  mem_exp_t    exp_mem_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [7:0]  exp_grant_q[$];

  int checks = 0;
  int failures = 0;
  int rsp_delay = 2;
  int stray_cnt = 0;
  int stray_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Memory contents seen by the responder; writes return zero data.
  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic we);
    if (we) return 32'h0;
    case (a)
      32'h100: return 32'h0000_0013;
      32'h104: return 32'h0000_0093;
      32'h200: return 32'hCAFE_0200;
      default: return 32'hBAD0_0000 | a;
    endcase
  endfunction

  function automatic mem_exp_t mk(input logic [31:0] a, input logic we,
                                  input logic [31:0] wd, input logic [3:0] ws,
                                  input logic f);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.wstrb = ws; e.is_fetch = f;
    return e;
  endfunction

  // Memory responder: checks each memory request and answers it after
  // rsp_delay cycles; can also inject a stray response.
  initial begin
    mem_exp_t e;
    logic [31:0] a;
    logic w;
    mem_rsp_valid = 0;
    mem_rsp_rdata = 0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done++;
        mem_rsp_valid = 1;
        mem_rsp_rdata = 32'h55;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
      end else if (rst && mem_req_valid && mem_req_ready) begin
        a = mem_addr;
        w = mem_we;
        if (exp_mem_q.size() == 0) begin
          fail_now("mem_req unexpected");
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e.wstrb});
          if (!e.is_fetch) chk("mem_wdata", mem_wdata, e.wdata);
        end
        @(posedge clk);
        repeat (rsp_delay - 1) @(posedge clk);
        #1;
        mem_rsp_valid = 1;
        mem_rsp_rdata = mem_data(a, w);
        @(posedge clk); #1;
        mem_rsp_valid = 0;
      end
    end
  end

  // Monitor: grant order and response data against the scoreboard queues.
  initial begin
    logic [7:0] g;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (if_req_valid && if_req_ready) begin
          if (exp_grant_q.size() == 0) fail_now("grant unexpected F");
          else begin
            g = exp_grant_q.pop_front();
            chk("grant_order", 32'(8'h46), 32'(g));
          end
        end
        if (d_req_valid && d_req_ready) begin
          if (exp_grant_q.size() == 0) fail_now("grant unexpected D");
          else begin
            g = exp_grant_q.pop_front();
            chk("grant_order", 32'(8'h44), 32'(g));
          end
        end
        if (if_req_ready && d_req_ready) fail_now("both_req_ready");
        if (if_rsp_valid && d_rsp_valid) fail_now("both_rsp_valid");
        if (if_rsp_valid && exp_if_q.size() == 0) fail_now("if_rsp_valid unexpected");
        if (d_rsp_valid && exp_d_q.size() == 0) fail_now("d_rsp_valid unexpected");
        if (if_rsp_valid && if_rsp_ready && exp_if_q.size() != 0) begin
          x = exp_if_q.pop_front();
          chk("if_rsp_data", if_rsp_data, x);
        end
        if (d_rsp_valid && d_rsp_ready && exp_d_q.size() != 0) begin
          x = exp_d_q.pop_front();
          chk("d_rsp_rdata", d_rsp_rdata, x);
        end
      end
    end
  end

  task automatic wait_fetch_grant();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_req_ready && n < 100);
    if (!if_req_ready) fail_now("fetch grant timeout");
    @(posedge clk); #1;
    if_req_valid = 0;
  endtask

  task automatic req_fetch(input logic [31:0] a);
    if_req_valid = 1;
    if_req_addr  = a;
    wait_fetch_grant();
  endtask

  task automatic req_data(input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    d_req_valid = 1; d_req_addr = a; d_req_we = we;
    d_req_wdata = wd; d_req_wstrb = ws;
    do begin
      @(negedge clk);
      n++;
    end while (!d_req_ready && n < 100);
    if (!d_req_ready) fail_now("data grant timeout");
    @(posedge clk); #1;
    d_req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_if_q.size() + exp_d_q.size() + exp_mem_q.size() + exp_grant_q.size()) != 0
           && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) fail_now("drain timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int mcnt, rcnt, rfirst, g, vcnt, rdy;
    logic saw_rsp;
    rst = 0;
    if_req_valid = 0; if_req_addr = 0; if_flush = 0; if_rsp_ready = 1;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0;
    d_req_wstrb = 0; d_rsp_ready = 1; mem_req_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_req_valid", {31'b0, mem_req_valid}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset if_rsp_valid", {31'b0, if_rsp_valid}, 0);
    chk("reset d_rsp_valid", {31'b0, d_rsp_valid}, 0);
    chk("reset if_rsp_data", if_rsp_data, 0);
    rst = 1;
    @(posedge clk); #1;

    // Single fetch at 0x100, response 0x13 two cycles after the handshake.
    exp_grant_q.push_back(8'h46);
    exp_mem_q.push_back(mk(32'h100, 0, 0, 0, 1));
    exp_if_q.push_back(32'h13);
    d_req_wdata = 32'h1234_5678;
    req_fetch(32'h100);
    mcnt = 0; rcnt = 0; rfirst = -1;
    for (int k = 0; k < 10; k++) begin
      mcnt += int'(mem_req_valid);
      if (if_rsp_valid) begin
        rcnt++;
        if (rfirst < 0) rfirst = k;
      end
      @(posedge clk); #1;
    end
    chk("single mem_req_valid cycles", mcnt, 1);
    chk("single if_rsp_valid cycles", rcnt, 1);
    chk("single if_rsp latency", rfirst, 3);
    drain();

    // Both requesters held: grant order D,D,D,D,F twice.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_grant_q.push_back(8'h44);
        exp_mem_q.push_back(mk(32'h200, 0, 0, 0, 0));
        exp_d_q.push_back(32'hCAFE_0200);
      end
      exp_grant_q.push_back(8'h46);
      exp_mem_q.push_back(mk(32'h104, 0, 0, 0, 1));
      exp_if_q.push_back(32'h93);
    end
    if_req_valid = 1; if_req_addr = 32'h104;
    d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
    g = 0;
    for (int n = 0; n < 400 && g < 10; n++) begin
      @(negedge clk);
      g += int'(if_req_valid && if_req_ready) + int'(d_req_valid && d_req_ready);
    end
    chk("starve grants seen", g, 10);
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    drain();

    // Data write with a stalled response; a waiting fetch must not be granted.
    exp_grant_q.push_back(8'h44);
    exp_mem_q.push_back(mk(32'h300, 1, 32'hDEAD_BEEF, 4'hF, 0));
    exp_d_q.push_back(32'h0);
    exp_grant_q.push_back(8'h46);
    exp_mem_q.push_back(mk(32'h104, 0, 0, 0, 1));
    exp_if_q.push_back(32'h93);
    d_rsp_ready = 0;
    req_data(32'h300, 1, 32'hDEAD_BEEF, 4'hF);
    if_req_valid = 1; if_req_addr = 32'h104;
    for (int n = 0; n < 50 && !d_rsp_valid; n++) begin
      @(posedge clk); #1;
    end
    vcnt = int'(d_rsp_valid); rdy = int'(if_req_ready);
    repeat (4) begin
      @(posedge clk); #1;
      vcnt += int'(d_rsp_valid); rdy += int'(if_req_ready);
    end
    d_rsp_ready = 1;
    @(posedge clk); #1;
    chk("stall d_rsp_valid cycles", vcnt, 5);
    chk("stall no grant while busy", rdy, 0);
    chk("stall d_rsp_valid after handshake", {31'b0, d_rsp_valid}, 0);
    wait_fetch_grant();
    drain();

    // Fetch flushed in RESP; waiting data request granted after mem response.
    rsp_delay = 4;
    exp_grant_q.push_back(8'h46);
    exp_mem_q.push_back(mk(32'h108, 0, 0, 0, 1));
    exp_grant_q.push_back(8'h44);
    exp_mem_q.push_back(mk(32'h200, 0, 0, 0, 0));
    exp_d_q.push_back(32'hCAFE_0200);
    req_fetch(32'h108);
    d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
    for (int n = 0; n < 50 && !(mem_req_valid && mem_req_ready); n++) @(negedge clk);
    @(posedge clk); #1;
    if_flush = 1;
    @(posedge clk); #1;
    if_flush = 0;
    saw_rsp = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_rsp_valid) saw_rsp = 1;
      if (d_req_valid && d_req_ready) break;
    end
    chk("flush data granted after mem rsp", {31'b0, saw_rsp}, 1);
    @(posedge clk); #1;
    d_req_valid = 0;
    drain();
    rsp_delay = 2;

    // Reset in REQ with memory stalled, then a stray memory response.
    exp_grant_q.push_back(8'h46);
    mem_req_ready = 0;
    req_fetch(32'h10C);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled mem_req_valid", {31'b0, mem_req_valid}, 1);
    chk("stalled mem_addr", mem_addr, 32'h10C);
    rst = 0;
    @(posedge clk); #1;
    chk("midreset mem_req_valid", {31'b0, mem_req_valid}, 0);
    chk("midreset mem_addr", mem_addr, 0);
    chk("midreset if_rsp_valid", {31'b0, if_rsp_valid}, 0);
    chk("midreset d_rsp_valid", {31'b0, d_rsp_valid}, 0);
    chk("midreset if_req_ready", {31'b0, if_req_ready}, 0);
    rst = 1;
    mem_req_ready = 1;
    stray_cnt++;
    vcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      vcnt += int'(if_rsp_valid) + int'(d_rsp_valid) + int'(mem_req_valid);
    end
    chk("stray response ignored", vcnt, 0);

    // Normal fetch after reset.
    exp_grant_q.push_back(8'h46);
    exp_mem_q.push_back(mk(32'h100, 0, 0, 0, 1));
    exp_if_q.push_back(32'h13);
    req_fetch(32'h100);
    drain();

    chk("scoreboard empty",
        exp_if_q.size() + exp_d_q.size() + exp_mem_q.size() + exp_grant_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
